// File: rtl/nnspc_seq_ctrl_if.sv
// Host/sequencer/nnspc signal bundle for the nnspc configuration sequencer.
interface nnspc_seq_ctrl_if;
   // Host requests
   logic       Start;
   logic [9:0] Word_in;
   logic       Scan_start;
   logic [3:0] Scan_dac;
   logic       Scan_re;
   logic [4:0] Nsel_first;
   logic [4:0] Nsel_last;
   logic       Meas_ack;
   logic       Abort;
   // Status back to the host
   logic       Busy;
   logic       Done;
   logic       Err;
   logic       Meas_req;
   logic [4:0] Cur_nsel;
   logic [9:0] Cfg_word;
   // nnspc configuration port
   logic       Spc_resetn;
   logic       Spc_cfg;

   modport master (
      output Start, Word_in, Scan_start, Scan_dac, Scan_re, Nsel_first, Nsel_last, Meas_ack,
             Abort,
      input  Busy, Done, Err, Meas_req, Cur_nsel, Cfg_word, Spc_resetn, Spc_cfg
   );

   modport slave (
      input  Start, Word_in, Scan_start, Scan_dac, Scan_re, Nsel_first, Nsel_last, Meas_ack,
             Abort,
      output Busy, Done, Err, Meas_req, Cur_nsel, Cfg_word, Spc_resetn, Spc_cfg
   );
endinterface

// File: rtl/nnspc_seq_ctrl.sv
// nnspc configuration sequencer: loads {NSEL, DAC, RE} serially (LSB first) after a reset
// pulse, either once on host command or repeatedly across a sensor range with a measurement
// handshake per sensor.
module nnspc_seq_ctrl #(
   parameter int unsigned RST_CYCLES    = 2,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned ACK_TIMEOUT   = 255
) (
   input logic             Clk,
   input logic             Resetn,
   nnspc_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StLrst, StShift, StSettle, StMeas, StNext, StFin
   } state_e;

   localparam logic [7:0] RstLast    = 8'(RST_CYCLES - 1);
   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] AckLast    = 8'(ACK_TIMEOUT - 1);
   localparam bit         SettleEn   = (SETTLE_CYCLES != 0);
   localparam bit         AckTmoEn   = (ACK_TIMEOUT != 0);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [9:0] word_q, word_d;
   logic       scan_q, scan_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       meas_req_q, meas_req_d;
   logic [4:0] cur_nsel_q, cur_nsel_d;
   logic [9:0] cfg_word_q, cfg_word_d;
   logic       spc_resetn_q, spc_resetn_d;
   logic       spc_cfg_q, spc_cfg_d;

   logic       start_load;
   state_e     post_load;

   // Next-state and registered-output logic for the load/scan sequencer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      word_d       = word_q;
      scan_d       = scan_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      meas_req_d   = meas_req_q;
      cur_nsel_d   = cur_nsel_q;
      cfg_word_d   = cfg_word_q;
      spc_resetn_d = spc_resetn_q;
      spc_cfg_d    = spc_cfg_q;
      start_load   = 1'b0;
      post_load    = scan_q ? StMeas : StFin;

      if (bus.Abort && (state_q != StIdle)) begin
         // Partial word is dropped; Cfg_word is only written on a complete shift.
         state_d      = StIdle;
         spc_resetn_d = 1'b1;
         meas_req_d   = 1'b0;
         done_d       = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Busy drops one edge after the Done pulse; requests wait until then.
               busy_d = 1'b0;
               if (!busy_q) begin
                  if (bus.Start) begin
                     word_d     = bus.Word_in;
                     scan_d     = 1'b0;
                     start_load = 1'b1;
                  end else if (bus.Scan_start) begin
                     if (bus.Nsel_first <= bus.Nsel_last) begin
                        word_d     = {bus.Nsel_first, bus.Scan_dac, bus.Scan_re};
                        scan_d     = 1'b1;
                        start_load = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               end
            end
            StLrst: begin
               if (cnt_q == RstLast) begin
                  state_d      = StShift;
                  spc_resetn_d = 1'b1;
                  spc_cfg_d    = word_q[0];
                  bit_cnt_d    = 4'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            StShift: begin
               if (bit_cnt_q == 4'd9) begin
                  cfg_word_d = word_q;
                  cnt_d      = 8'd0;
                  state_d    = SettleEn ? StSettle : post_load;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  spc_cfg_d = word_q[bit_cnt_d];
               end
            end
            StSettle: begin
               if (cnt_q == SettleLast) begin
                  state_d = post_load;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            StMeas: begin
               // An ack on the final allowed cycle still counts as a good handshake.
               if (bus.Meas_ack) begin
                  meas_req_d = 1'b0;
                  state_d    = StNext;
               end else if (AckTmoEn && (cnt_q == AckLast)) begin
                  err_d      = 1'b1;
                  meas_req_d = 1'b0;
                  state_d    = StNext;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            StNext: begin
               if ((word_q[9:5] >= bus.Nsel_last) || (word_q[9:5] == 5'd31)) begin
                  state_d = StFin;
               end else begin
                  word_d     = {word_q[9:5] + 5'd1, word_q[4:0]};
                  start_load = 1'b1;
               end
            end
            StFin: begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      if (start_load) begin
         state_d      = StLrst;
         cnt_d        = 8'd0;
         busy_d       = 1'b1;
         spc_resetn_d = 1'b0;
         cur_nsel_d   = word_d[9:5];
      end

      if ((state_d == StMeas) && (state_q != StMeas)) begin
         meas_req_d = 1'b1;
         cnt_d      = 8'd0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q      <= StIdle;
         cnt_q        <= 8'd0;
         bit_cnt_q    <= 4'd0;
         word_q       <= 10'd0;
         scan_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         meas_req_q   <= 1'b0;
         cur_nsel_q   <= 5'd0;
         cfg_word_q   <= 10'd0;
         spc_resetn_q <= 1'b1;
         spc_cfg_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         word_q       <= word_d;
         scan_q       <= scan_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         meas_req_q   <= meas_req_d;
         cur_nsel_q   <= cur_nsel_d;
         cfg_word_q   <= cfg_word_d;
         spc_resetn_q <= spc_resetn_d;
         spc_cfg_q    <= spc_cfg_d;
      end
   end

   assign bus.Busy       = busy_q;
   assign bus.Done       = done_q;
   assign bus.Err        = err_q;
   assign bus.Meas_req   = meas_req_q;
   assign bus.Cur_nsel   = cur_nsel_q;
   assign bus.Cfg_word   = cfg_word_q;
   assign bus.Spc_resetn = spc_resetn_q;
   assign bus.Spc_cfg    = spc_cfg_q;

endmodule

// File: tb/tb_nnspc_seq_ctrl.sv
// Self-checking bench for nnspc_seq_ctrl: directed cases plus randomized single writes and
// scans, checked against expectations computed from the sequencing rules.
module tb_nnspc_seq_ctrl;

   localparam int RstCycles    = 2;
   localparam int SettleCycles = 4;
   localparam int AckTimeout   = 8;

   logic Clk    = 1'b0;
   logic Resetn = 1'b1;

   nnspc_seq_ctrl_if u_if ();

   nnspc_seq_ctrl #(
      .RST_CYCLES   (RstCycles),
      .SETTLE_CYCLES(SettleCycles),
      .ACK_TIMEOUT  (AckTimeout)
   ) u_dut (
      .Clk   (Clk),
      .Resetn(Resetn),
      .bus   (u_if)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Passive monitor: reconstructs each serial word after a reset release and tallies pulses.
   logic [9:0] cap_word = '0;
   int         cap_n    = -1;
   int         low_run  = 0;
   logic       prev_rn  = 1'b1;
   logic       prev_req = 1'b0;
   logic [9:0] cap_q[$];
   int         low_q[$];
   int         req_eps  = 0;
   int         err_cnt  = 0;
   int         done_cnt = 0;

   always @(negedge Clk) begin
      if (!Resetn) begin
         cap_n    = -1;
         low_run  = 0;
         prev_rn  = 1'b1;
         prev_req = 1'b0;
      end else begin
         if (cap_n >= 0) begin
            cap_word[cap_n] = u_if.Spc_cfg;
            cap_n++;
            if (cap_n == 10) begin
               cap_q.push_back(cap_word);
               cap_n = -1;
            end
         end
         if (!u_if.Spc_resetn) begin
            low_run++;
         end else if (!prev_rn) begin
            low_q.push_back(low_run);
            low_run     = 0;
            cap_word    = '0;
            cap_word[0] = u_if.Spc_cfg;
            cap_n       = 1;
         end
         prev_rn = u_if.Spc_resetn;
         if (u_if.Meas_req && !prev_req) req_eps++;
         prev_req = u_if.Meas_req;
         if (u_if.Err) err_cnt++;
         if (u_if.Done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_single(input logic [9:0] w, input bit poke);
      int lat;
      int cap0;
      int low0;
      cap0 = cap_q.size();
      low0 = low_q.size();
      u_if.Word_in = w;
      u_if.Start   = 1'b1;
      if (poke) begin
         // Simultaneous legal scan request must lose to Start.
         u_if.Scan_start = 1'b1;
         u_if.Nsel_first = 5'd0;
         u_if.Nsel_last  = 5'd3;
      end
      tick();
      u_if.Start      = 1'b0;
      u_if.Scan_start = 1'b0;
      check_eq("single_busy_on", u_if.Busy, 1);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         if (poke && k == 5) begin
            u_if.Word_in = ~w;
            u_if.Start   = 1'b1;
         end
         if (poke && k == 6) u_if.Start = 1'b0;
         tick();
         if (u_if.Done) begin
            lat = k;
            break;
         end
      end
      check_eq("single_latency", lat, RstCycles + 10 + SettleCycles + 1);
      check_eq("single_cfg_word", u_if.Cfg_word, w);
      check_eq("single_cur_nsel", u_if.Cur_nsel, w[9:5]);
      check_eq("single_cfg_hold_bit9", u_if.Spc_cfg, w[9]);
      check_eq("single_nloads", cap_q.size() - cap0, 1);
      if (cap_q.size() > cap0) check_eq("single_stream", cap_q[cap0], w);
      if (low_q.size() > low0) check_eq("single_rst_len", low_q[low0], RstCycles);
      tick();
      check_eq("single_done_pulse", u_if.Done, 0);
      check_eq("single_busy_drop", u_if.Busy, 0);
   endtask

   // delay = cycles from Meas_req rising to the ack edge; 0 = never acknowledge.
   task automatic do_scan(input logic [4:0] first, input logic [4:0] last, input logic [3:0] dac,
                          input logic re, input int delay);
      int cap0, low0, req0, err0, done0;
      int n, m, lat, req_cyc;
      logic [9:0] exp_w;
      cap0    = cap_q.size();
      low0    = low_q.size();
      req0    = req_eps;
      err0    = err_cnt;
      done0   = done_cnt;
      n       = int'(last) - int'(first) + 1;
      m       = (delay == 0) ? AckTimeout : delay;
      lat     = -1;
      req_cyc = 0;
      u_if.Nsel_first = first;
      u_if.Nsel_last  = last;
      u_if.Scan_dac   = dac;
      u_if.Scan_re    = re;
      u_if.Scan_start = 1'b1;
      tick();
      u_if.Scan_start = 1'b0;
      check_eq("scan_busy_on", u_if.Busy, 1);
      for (int k = 1; k <= 3000; k++) begin
         tick();
         u_if.Meas_ack = 1'b0;
         if (u_if.Done) begin
            lat = k;
            break;
         end
         if (u_if.Meas_req) begin
            req_cyc++;
            if (delay != 0 && req_cyc == delay) u_if.Meas_ack = 1'b1;
         end else begin
            req_cyc = 0;
         end
      end
      check_eq("scan_latency", lat, n * (RstCycles + 10 + SettleCycles + m + 1) + 1);
      check_eq("scan_cfg_word", u_if.Cfg_word, {last, dac, re});
      check_eq("scan_cur_nsel", u_if.Cur_nsel, last);
      tick();
      check_eq("scan_busy_drop", u_if.Busy, 0);
      check_eq("scan_nloads", cap_q.size() - cap0, n);
      for (int i = 0; i < n; i++) begin
         exp_w = {5'(int'(first) + i), dac, re};
         if (cap_q.size() > cap0 + i) check_eq("scan_stream", cap_q[cap0 + i], exp_w);
         if (low_q.size() > low0 + i) check_eq("scan_rst_len", low_q[low0 + i], RstCycles);
      end
      check_eq("scan_req_episodes", req_eps - req0, n);
      check_eq("scan_err_pulses", err_cnt - err0, (delay == 0) ? n : 0);
      check_eq("scan_done_pulses", done_cnt - done0, 1);
   endtask

   initial begin
      logic [4:0] f;
      logic [4:0] l;
      int         err0;
      u_if.Start      = 1'b0;
      u_if.Word_in    = '0;
      u_if.Scan_start = 1'b0;
      u_if.Scan_dac   = '0;
      u_if.Scan_re    = 1'b0;
      u_if.Nsel_first = '0;
      u_if.Nsel_last  = '0;
      u_if.Meas_ack   = 1'b0;
      u_if.Abort      = 1'b0;
      #1 Resetn = 1'b0;
      #2;
      check_eq("rst_busy", u_if.Busy, 0);
      check_eq("rst_done", u_if.Done, 0);
      check_eq("rst_err", u_if.Err, 0);
      check_eq("rst_meas_req", u_if.Meas_req, 0);
      check_eq("rst_cur_nsel", u_if.Cur_nsel, 0);
      check_eq("rst_cfg_word", u_if.Cfg_word, 0);
      check_eq("rst_spc_resetn", u_if.Spc_resetn, 1);
      check_eq("rst_spc_cfg", u_if.Spc_cfg, 0);
      repeat (2) @(posedge Clk);
      #3 Resetn = 1'b1;
      tick();

      // Single write, then a back-to-back second write.
      do_single(10'h159, 1'b0);
      do_single(10'h2A6, 1'b0);

      // Scan 3..5 with ack three cycles after each request.
      do_scan(5'd3, 5'd5, 4'hC, 1'b1, 3);

      // Illegal range: Err only, no activity.
      err0 = err_cnt;
      u_if.Nsel_first = 5'd9;
      u_if.Nsel_last  = 5'd4;
      u_if.Scan_start = 1'b1;
      tick();
      u_if.Scan_start = 1'b0;
      check_eq("illegal_err", u_if.Err, 1);
      check_eq("illegal_busy", u_if.Busy, 0);
      check_eq("illegal_done", u_if.Done, 0);
      check_eq("illegal_spc_resetn", u_if.Spc_resetn, 1);
      tick();
      check_eq("illegal_err_pulse", u_if.Err, 0);
      check_eq("illegal_busy_after", u_if.Busy, 0);
      tick();
      check_eq("illegal_err_count", err_cnt - err0, 1);

      // Timeout on every sensor of a 30..31 scan.
      do_scan(5'd30, 5'd31, 4'h5, 1'b0, 0);

      // Randomized single writes and scans.
      for (int i = 0; i < 6; i++) begin
         do_single(10'($urandom), i[0]);
      end
      for (int i = 0; i < 4; i++) begin
         f = 5'($urandom_range(0, 31));
         l = 5'(int'(f) + $urandom_range(0, (31 - int'(f)) < 3 ? (31 - int'(f)) : 3));
         do_scan(f, l, 4'($urandom), 1'($urandom), $urandom_range(1, 6));
      end

      // Abort during bit 4 of 0x2A6 after a committed 0x159.
      do_single(10'h159, 1'b0);
      u_if.Word_in = 10'h2A6;
      u_if.Start   = 1'b1;
      tick();
      u_if.Start = 1'b0;
      repeat (RstCycles + 4) tick();
      check_eq("abort_at_bit4", u_if.Spc_cfg, 0);
      u_if.Abort = 1'b1;
      tick();
      u_if.Abort = 1'b0;
      check_eq("abort_done", u_if.Done, 1);
      check_eq("abort_spc_resetn", u_if.Spc_resetn, 1);
      check_eq("abort_meas_req", u_if.Meas_req, 0);
      check_eq("abort_cfg_word", u_if.Cfg_word, 10'h159);
      check_eq("abort_cur_nsel", u_if.Cur_nsel, 5'h15);
      tick();
      check_eq("abort_done_pulse", u_if.Done, 0);
      check_eq("abort_busy", u_if.Busy, 0);
      repeat (12) tick();
      check_eq("abort_cfg_keep", u_if.Cfg_word, 10'h159);

      // Asynchronous reset while the first scan load holds Spc_resetn low.
      u_if.Nsel_first = 5'd3;
      u_if.Nsel_last  = 5'd5;
      u_if.Scan_start = 1'b1;
      tick();
      u_if.Scan_start = 1'b0;
      check_eq("arst_pre_spc_resetn", u_if.Spc_resetn, 0);
      Resetn = 1'b0;
      #1;
      check_eq("arst_busy", u_if.Busy, 0);
      check_eq("arst_spc_resetn", u_if.Spc_resetn, 1);
      check_eq("arst_cfg_word", u_if.Cfg_word, 0);
      check_eq("arst_cur_nsel", u_if.Cur_nsel, 0);
      check_eq("arst_meas_req", u_if.Meas_req, 0);
      check_eq("arst_spc_cfg", u_if.Spc_cfg, 0);
      #1 Resetn = 1'b1;
      repeat (3) tick();
      check_eq("arst_stays_idle", u_if.Busy, 0);
      check_eq("arst_no_done", u_if.Done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_tests);
      $fatal(1);
   end

endmodule
